serial_adder: RTL

//   Bit-serial ripple adder: the addition counterpart of the subtractor cells.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder_full_adder.sv | 18 +
 rtl/serial_adder.sv | 85 ++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
interface serial_adder_if import serial_adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, S, Cout
  );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from gate primitives.
module full_adder (
  input  wire a,
  input  wire b,
  input  wire cin,
  output wire s,
  output wire cout
);
  wire ab_x;
  wire ab_a;
  wire c_x;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_x, cin, ab_x);
  or  g_o0 (cout, ab_a, c_x);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one full-adder cell, one bit per clock.
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_q;
  logic             carry;
  logic             cout_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      s_q         <= '0;
      carry       <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            carry <= bus.Cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          s_q   <= {fa_s, s_q[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          if (cnt == LAST) begin
            cnt         <= '0;
            cout_q      <= fa_co;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
endmodule
